fdd_image_server: RTL and testbench
===================================

Name: fdd_image_server

Overview:
- Responder side of the floppy-controller sector interface: serves `sd_rd`/`sd_wr` sector requests from a WD1793-based disk cartridge.
- The disk image is held in a byte-wide backing memory (BRAM/SDRAM port) instead of HPS.
- It generates `sd_ack`, streams 512-byte sectors into the controller buffer on reads, and drains the buffer back to memory on writes.
- Sits between the FDC cartridge's sd_* port and a memory arbiter.

Parameters:
- MEM_AW, 20, byte address width of image memory (1 MiB; covers 720 KiB images).
- IDLE_GAP, 1, cycles the block stays in IDLE after `sd_ack` falls before sampling a new request.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- img_mounted  in  1  one-cycle pulse; latches `img_size` and `img_wp`
- img_size  in  32  image size in bytes
- img_wp  in  1  write protect
- sd_lba  in  32  requested sector number
- sd_rd  in  1  read request level; held by the initiator until `sd_ack` rises
- sd_wr  in  1  write request level; same rule as `sd_rd`
- sd_ack  out  1  high for the whole transfer
- sd_buff_addr  out  9  byte index within the sector
- sd_buff_dout  out  8  read data to the controller buffer
- sd_buff_wr  out  1  one-cycle write strobe into the controller buffer
- sd_buff_din  in  8  controller buffer data; valid 1 cycle after `sd_buff_addr` changes
- mem_addr  out  MEM_AW  backing memory byte address
- mem_rd  out  1  read request; held until `mem_ready`
- mem_wr  out  1  write request; held until `mem_ready`
- mem_din  out  8  write data
- mem_dout  in  8  read data; valid in the `mem_ready` cycle
- mem_ready  in  1  completion of the current access; latency is arbitrary (≥1 cycle)

Behaviour:
- Reset values: `sd_ack`=0, `sd_buff_addr`=0, `sd_buff_dout`=FF, `sd_buff_wr`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_din`=0.
- Reset also clears the latched size to 0 and latched wp to 0, and sets state to IDLE.
- Reset mid-transfer: everything drops immediately; no completion is signalled.
- `img_mounted`: latches `size_q` = `img_size` and `wp_q` = `img_wp`.
  - If it arrives mid-transfer, the latch still happens.
  - The current transfer continues using the `range_ok` value captured at its start.
- Request acceptance:
  - In IDLE with the gap satisfied, `sd_rd` has priority over `sd_wr`.
  - On accept: capture `sd_lba`; compute `range_ok` = (`sd_lba[31:MEM_AW-9]`==0) and ({`lba`,9'h000} + 512 ≤ `size_q`).
  - Set `sd_ack`=1 on the next cycle; byte counter `i`=0.
- Address: `mem_addr` = {`lba[MEM_AW-10:0]`, `i[8:0]`}.
- States: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_REQ, DONE.
- Read path:
  - RD_REQ: if `range_ok`, assert `mem_rd` and wait for `mem_ready`; capture `mem_dout`.
  - If not `range_ok`, data = FF with no memory access (1 cycle).
  - RD_PUT: drive `sd_buff_addr`=`i` and `sd_buff_dout`=data; pulse `sd_buff_wr` for exactly 1 cycle.
  - If `i`==511 go to DONE, else `i`++ and return to RD_REQ.
- Write path:
  - WR_ADDR: drive `sd_buff_addr`=`i` and hold one cycle for buffer read latency.
  - WR_REQ: sample `sd_buff_din` into `mem_din`.
  - If `range_ok` and !`wp_q`, assert `mem_wr` until `mem_ready`; otherwise discard the byte (1 cycle).
  - Then `i`==511 → DONE, else `i`++ → WR_ADDR.
- DONE:
  - Deassert `sd_ack`; `sd_buff_wr`=0.
  - Wait IDLE_GAP cycles, then sample requests again.
  - If `sd_rd`/`sd_wr` are still high after the gap, they start a new transfer (the initiator must drop the request once `sd_ack` is seen).
- `mem_rd` and `mem_wr` are never high together, and never high while `sd_ack`=0.
- `i` is 9-bit and wraps only by leaving via DONE; exactly 512 `sd_buff_wr` pulses per read, exactly 512 sampled bytes per write.

Decomposition:
- Shared package `fdd_pkg`:
  - SECTOR_BYTES=512, SECTOR_SHIFT=9.
  - State enum.
  - Byte-address helper function lba→base.
- Single module, no sub-modules.
- Optional sub-module: `fdd_range_check`, purely combinational (size/lba compare), reusable by other disk cartridges.

Test Plan:
- Mount size 737280, memory pattern byte[a]=a[7:0]^a[15:8]; `sd_rd` with lba=3 → `sd_ack` high, 512 `sd_buff_wr` pulses, byte `i` = pattern(1536+`i`), `sd_ack` low after last pulse.
- `sd_wr` lba=5, buffer filled with 0x00..0xFF repeating, `img_wp`=0 → memory 2560..3071 matches, `mem_wr` count 512.
- Same write with `img_wp`=1 → `sd_ack` cycle completes, zero `mem_wr`, memory unchanged.
- `sd_rd` lba=1440 with size 737280 (out of range) → 512 bytes of FF, zero `mem_rd`.
- `mem_ready` random latency 1–7 cycles, `sd_rd` and `sd_wr` asserted same cycle → read served first, then write after the IDLE_GAP; data correct.
- Assert reset at byte 200 of a read → `sd_ack`, `mem_rd`, `sd_buff_wr` low immediately; next read after release returns a full correct sector.

Source files
------------

// File: rtl/fdd_pkg.sv
// rtl/fdd_pkg.sv - shared constants, state encoding and sector address helper for the image server
package fdd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = 9;
  // Width of a full byte address built from a 32-bit LBA, plus one guard bit for the end-of-sector sum
  localparam int BASE_W       = 32 + SECTOR_SHIFT + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_PUT,
    ST_WR_ADDR,
    ST_WR_REQ,
    ST_DONE
  } state_e;

  // Byte address of the first byte of sector lba; wide enough that no LBA can overflow it
  function automatic logic [BASE_W-1:0] lba_base(input logic [31:0] lba);
    return {1'b0, lba, {SECTOR_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/fdd_range_check.sv
// rtl/fdd_range_check.sv - combinational check that a whole sector lies inside the image and the memory window
module fdd_range_check
  import fdd_pkg::*;
#(
  parameter int MEM_AW = 20
) (
  input  logic [31:0] lba_i,
  input  logic [31:0] size_i,
  output logic        ok_o
);

  logic [BASE_W-1:0] end_addr;

  // Sector end (exclusive) must not pass the image size, and the LBA must fit the memory window
  always_comb begin
    end_addr = lba_base(lba_i) + BASE_W'(SECTOR_BYTES);
    ok_o     = (lba_i[31:MEM_AW-SECTOR_SHIFT] == '0) &&
               (end_addr <= {{(BASE_W-32){1'b0}}, size_i});
  end

endmodule

// File: rtl/fdd_image_server.sv
// rtl/fdd_image_server.sv - serves FDC sector read/write requests from a byte-wide image memory
module fdd_image_server
  import fdd_pkg::*;
#(
  parameter int MEM_AW   = 20,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              img_mounted,
  input  logic [31:0]       img_size,
  input  logic              img_wp,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready
);

  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam int LW = MEM_AW - SECTOR_SHIFT;

  state_e          state_q;
  logic [LW-1:0]   lba_q;
  logic [8:0]      i_q;
  logic [7:0]      data_q;
  logic            range_ok_q;
  logic            range_ok_d;
  logic [GW-1:0]   gap_q;
  logic [31:0]     size_q;
  logic            wp_q;
  logic            sd_ack_q;
  logic [8:0]      sd_buff_addr_q;
  logic [7:0]      sd_buff_dout_q;
  logic            sd_buff_wr_q;
  logic            mem_rd_q;
  logic            mem_wr_q;
  logic [7:0]      mem_din_q;

  fdd_range_check #(
    .MEM_AW (MEM_AW)
  ) u_range (
    .lba_i  (sd_lba),
    .size_i (size_q),
    .ok_o   (range_ok_d)
  );

  // Image geometry latch; kept apart from the FSM so a mount during a transfer still takes effect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q <= '0;
      wp_q   <= 1'b0;
    end else if (img_mounted) begin
      size_q <= img_size;
      wp_q   <= img_wp;
    end
  end

  // Transfer FSM: accepts a request, moves 512 bytes one at a time, then idles for the gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lba_q          <= '0;
      i_q            <= '0;
      data_q         <= 8'hFF;
      range_ok_q     <= 1'b0;
      gap_q          <= '0;
      sd_ack_q       <= 1'b0;
      sd_buff_addr_q <= '0;
      sd_buff_dout_q <= 8'hFF;
      sd_buff_wr_q   <= 1'b0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_din_q      <= '0;
    end else begin
      sd_buff_wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
          end else if (sd_rd || sd_wr) begin
            lba_q          <= sd_lba[LW-1:0];
            range_ok_q     <= range_ok_d;
            sd_ack_q       <= 1'b1;
            i_q            <= '0;
            sd_buff_addr_q <= '0;
            state_q        <= sd_rd ? ST_RD_REQ : ST_WR_ADDR;
          end
        end
        ST_RD_REQ: begin
          if (!range_ok_q) begin
            data_q  <= 8'hFF;
            state_q <= ST_RD_PUT;
          end else if (!mem_rd_q) begin
            mem_rd_q <= 1'b1;
          end else if (mem_ready) begin
            mem_rd_q <= 1'b0;
            data_q   <= mem_dout;
            state_q  <= ST_RD_PUT;
          end
        end
        ST_RD_PUT: begin
          sd_buff_addr_q <= i_q;
          sd_buff_dout_q <= data_q;
          sd_buff_wr_q   <= 1'b1;
          if (i_q == 9'd511) begin
            state_q <= ST_DONE;
          end else begin
            i_q     <= i_q + 9'd1;
            state_q <= ST_RD_REQ;
          end
        end
        ST_WR_ADDR: begin
          state_q <= ST_WR_REQ;
        end
        ST_WR_REQ: begin
          if (!mem_wr_q) begin
            mem_din_q <= sd_buff_din;
          end
          if (!mem_wr_q && range_ok_q && !wp_q) begin
            mem_wr_q <= 1'b1;
          end else if (!mem_wr_q || mem_ready) begin
            mem_wr_q <= 1'b0;
            if (i_q == 9'd511) begin
              state_q <= ST_DONE;
            end else begin
              i_q            <= i_q + 9'd1;
              sd_buff_addr_q <= i_q + 9'd1;
              state_q        <= ST_WR_ADDR;
            end
          end
        end
        ST_DONE: begin
          sd_ack_q <= 1'b0;
          gap_q    <= GW'(IDLE_GAP);
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sd_ack       = sd_ack_q;
  assign sd_buff_addr = sd_buff_addr_q;
  assign sd_buff_dout = sd_buff_dout_q;
  assign sd_buff_wr   = sd_buff_wr_q;
  assign mem_addr     = {lba_q, i_q};
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_din      = mem_din_q;

endmodule

// File: tb/tb_fdd_image_server.sv
// tb/tb_fdd_image_server.sv - self-checking bench for fdd_image_server against a sector-level memory model
module tb_fdd_image_server;

  localparam int MEM_AW   = 20;
  localparam int IDLE_GAP = 1;
  localparam int MEM_SZ   = 1 << MEM_AW;

  logic              clk          = 1'b0;
  logic              reset        = 1'b1;
  logic              img_mounted  = 1'b0;
  logic [31:0]       img_size     = '0;
  logic              img_wp       = 1'b0;
  logic [31:0]       sd_lba       = '0;
  logic              sd_rd        = 1'b0;
  logic              sd_wr        = 1'b0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din  = '0;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout     = '0;
  logic              mem_ready    = 1'b0;

  always #5 clk = ~clk;

  fdd_image_server #(
    .MEM_AW   (MEM_AW),
    .IDLE_GAP (IDLE_GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_wp       (img_wp),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_ready    (mem_ready)
  );

  // Backing memory: fixed pattern overlaid with whatever the DUT has written
  logic [7:0] wmem [0:MEM_SZ-1];
  bit         wval [0:MEM_SZ-1];

  function automatic logic [7:0] pat(input int unsigned a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [7:0] mem_view(input int unsigned a);
    return wval[a] ? wmem[a] : pat(a);
  endfunction

  int unsigned lat_q = 1;
  int unsigned cnt_q = 0;

  // Memory responder with a random 1..7 cycle latency per access
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      cnt_q     <= 0;
      lat_q     <= $urandom_range(1, 7);
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
      cnt_q     <= 0;
      lat_q     <= $urandom_range(1, 7);
    end else if (mem_rd || mem_wr) begin
      cnt_q <= cnt_q + 1;
      if (cnt_q + 1 == lat_q) begin
        mem_ready <= 1'b1;
        if (mem_rd) begin
          mem_dout <= mem_view(int'(mem_addr));
        end else begin
          wmem[mem_addr] <= mem_din;
          wval[mem_addr] <= 1'b1;
        end
      end
    end
  end

  // Controller buffer: source bytes for writes, one-cycle read latency
  logic [7:0] src [0:511];
  always @(posedge clk) sd_buff_din <= src[sd_buff_addr];

  // Monitors: capture read strobes per transfer and count accesses / protocol violations
  logic        prev_ack = 1'b0;
  int unsigned idx = 0;
  int unsigned n_rd_done = 0, n_wr_done = 0, n_viol = 0, n_pulse = 0;
  logic [7:0]  cap      [0:511];
  logic [8:0]  cap_addr [0:511];

  always @(posedge clk) begin
    prev_ack <= sd_ack;
    if (mem_ready && mem_rd) n_rd_done <= n_rd_done + 1;
    if (mem_ready && mem_wr) n_wr_done <= n_wr_done + 1;
    if ((mem_rd && mem_wr) || ((mem_rd || mem_wr) && !sd_ack) || (sd_buff_wr && !sd_ack))
      n_viol <= n_viol + 1;
    if (sd_buff_wr) n_pulse <= n_pulse + 1;
    if (sd_ack && !prev_ack) begin
      idx <= 0;
    end else if (sd_buff_wr) begin
      if (idx < 512) begin
        cap[idx]      <= sd_buff_dout;
        cap_addr[idx] <= sd_buff_addr;
      end
      idx <= idx + 1;
    end
  end

  // Reference model: image contents and mounted geometry at sector granularity
  logic [7:0]  ref_mem [0:MEM_SZ-1];
  logic [31:0] size_m = '0;
  bit          wp_m   = 1'b0;

  int unsigned n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit sector_ok(input logic [31:0] lba);
    longint unsigned end_b;
    end_b = (64'(lba) + 64'd1) * 64'd512;
    return (64'(lba) < 64'(MEM_SZ / 512)) && (end_b <= 64'(size_m));
  endfunction

  function automatic int cap_bad(input logic [31:0] lba, input bit ok_s);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      e = ok_s ? ref_mem[lba * 512 + k] : 8'hFF;
      if (cap[k] !== e || cap_addr[k] !== 9'(k)) bad++;
    end
    return bad;
  endfunction

  function automatic int region_bad(input logic [31:0] lba);
    int bad;
    bad = 0;
    for (int k = 0; k < 512; k++)
      if (mem_view(lba * 512 + k) !== ref_mem[lba * 512 + k]) bad++;
    return bad;
  endfunction

  task automatic wait_ack(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (sd_ack === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic mount(input logic [31:0] sz, input bit wp);
    @(negedge clk);
    img_size    = sz;
    img_wp      = wp;
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
    size_m = sz;
    wp_m   = wp;
  endtask

  task automatic xfer(input bit do_wr, input logic [31:0] lba, input string tag);
    int unsigned rd0, wr0, p0;
    bit ok_s, ok;
    rd0  = n_rd_done;
    wr0  = n_wr_done;
    p0   = n_pulse;
    ok_s = sector_ok(lba);
    @(negedge clk);
    sd_lba = lba;
    if (do_wr) sd_wr = 1'b1; else sd_rd = 1'b1;
    wait_ack(1'b1, ok);
    check({tag, "_ack_rise"}, 64'(ok), 64'd1);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    wait_ack(1'b0, ok);
    check({tag, "_ack_fall"}, 64'(ok), 64'd1);
    if (!do_wr) begin
      check({tag, "_pulses"}, 64'(n_pulse - p0), 64'd512);
      check({tag, "_data_bad"}, 64'(cap_bad(lba, ok_s)), 64'd0);
      check({tag, "_mem_rd"}, 64'(n_rd_done - rd0), ok_s ? 64'd512 : 64'd0);
    end else begin
      if (ok_s && !wp_m)
        for (int k = 0; k < 512; k++) ref_mem[lba * 512 + k] = src[k];
      check({tag, "_pulses"}, 64'(n_pulse - p0), 64'd0);
      check({tag, "_mem_wr"}, 64'(n_wr_done - wr0), (ok_s && !wp_m) ? 64'd512 : 64'd0);
    end
    if (64'(lba) < 64'(MEM_SZ / 512))
      check({tag, "_mem_bad"}, 64'(region_bad(lba)), 64'd0);
  endtask

  initial begin : stim
    bit ok;
    int unsigned rd0, wr0, p0, n;
    logic [31:0] lba;

    for (int a = 0; a < MEM_SZ; a++) ref_mem[a] = pat(a);
    for (int k = 0; k < 512; k++) src[k] = 8'(k);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", 64'(sd_ack), 64'd0);
    check("rst_baddr", 64'(sd_buff_addr), 64'd0);
    check("rst_bdout", 64'(sd_buff_dout), 64'hFF);
    check("rst_bwr", 64'(sd_buff_wr), 64'd0);
    check("rst_mrd", 64'(mem_rd), 64'd0);
    check("rst_mwr", 64'(mem_wr), 64'd0);
    check("rst_maddr", 64'(mem_addr), 64'd0);
    check("rst_mdin", 64'(mem_din), 64'd0);
    reset = 1'b0;

    mount(32'd737280, 1'b0);
    xfer(1'b0, 32'd3, "rd3");
    xfer(1'b1, 32'd5, "wr5");
    mount(32'd737280, 1'b1);
    xfer(1'b1, 32'd6, "wr6_wp");
    mount(32'd737280, 1'b0);
    xfer(1'b0, 32'd1440, "rd1440_oor");
    xfer(1'b0, 32'd1439, "rd1439_last");
    mount(32'hFFFF_FFFF, 1'b0);
    xfer(1'b0, 32'd2048, "rd2048_win");
    mount(32'd737280, 1'b0);

    // Read and write requested together: read first, then write after the gap
    for (int k = 0; k < 512; k++) src[k] = 8'($urandom);
    rd0 = n_rd_done;
    wr0 = n_wr_done;
    p0  = n_pulse;
    @(negedge clk);
    sd_lba = 32'd9;
    sd_rd  = 1'b1;
    sd_wr  = 1'b1;
    wait_ack(1'b1, ok);
    check("both_ack1", 64'(ok), 64'd1);
    sd_rd = 1'b0;
    wait_ack(1'b0, ok);
    check("both_fall1", 64'(ok), 64'd1);
    check("both_rd_pulses", 64'(n_pulse - p0), 64'd512);
    check("both_rd_first", 64'(cap_bad(32'd9, 1'b1)), 64'd0);
    check("both_no_wr_yet", 64'(n_wr_done - wr0), 64'd0);
    n = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (sd_ack) break;
      n++;
    end
    check("both_gap", 64'(n), 64'(IDLE_GAP + 1));
    check("both_ack2", 64'(sd_ack), 64'd1);
    sd_wr = 1'b0;
    wait_ack(1'b0, ok);
    check("both_fall2", 64'(ok), 64'd1);
    for (int k = 0; k < 512; k++) ref_mem[9 * 512 + k] = src[k];
    check("both_mem_wr", 64'(n_wr_done - wr0), 64'd512);
    check("both_mem_rd", 64'(n_rd_done - rd0), 64'd512);
    check("both_mem_bad", 64'(region_bad(32'd9)), 64'd0);

    // Randomized transfers
    for (int t = 0; t < 4; t++) begin
      mount(32'd737280, 1'($urandom_range(0, 1)));
      lba = $urandom_range(0, 1449);
      for (int k = 0; k < 512; k++) src[k] = 8'($urandom);
      xfer(1'($urandom_range(0, 1)), lba, $sformatf("rnd%0d", t));
    end

    // Reset in the middle of a read
    mount(32'd737280, 1'b0);
    @(negedge clk);
    sd_lba = 32'd7;
    sd_rd  = 1'b1;
    wait_ack(1'b1, ok);
    check("mid_ack", 64'(ok), 64'd1);
    sd_rd = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (idx >= 200) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_reach200", 64'(ok), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_ack", 64'(sd_ack), 64'd0);
    check("mid_rst_mrd", 64'(mem_rd), 64'd0);
    check("mid_rst_bwr", 64'(sd_buff_wr), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mount(32'd737280, 1'b0);
    xfer(1'b0, 32'd7, "post_rst_rd7");

    check("protocol_viol", 64'(n_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
